// File: rtl/sys_axi_pkg.sv
// Shared AXI AW definitions: payload struct, burst encodings, 4 KiB shift.
// Width defaults come from `AXI_ID_WIDTH / `AXI_ADDR_WIDTH when the build
// does not provide them.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package sys_axi_pkg;

  localparam int unsigned AXI_ID_W     = `AXI_ID_WIDTH;
  localparam int unsigned AXI_ADDR_W   = `AXI_ADDR_WIDTH;
  localparam int unsigned AXI_4K_SHIFT = 12;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  // One buffered AW beat; field order here fixes the stored word layout.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
  } aw_payload_t;

endpackage

// File: rtl/sys_axi_aw.sv
// AXI write-address channel bundle with master/slave views.
interface sys_axi_aw #(
  parameter int unsigned ID_W   = `AXI_ID_WIDTH,
  parameter int unsigned ADDR_W = `AXI_ADDR_WIDTH
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [3:0]        awregion;
  logic              awvalid;
  logic              awready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    input  awready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    output awready
  );
endinterface

// File: rtl/sys_axi_aw_4kchk.sv
// Combinational 4 KiB boundary detector for INCR bursts.
// Only instantiated when SYS_AXI_AW_FIFO_4K_CHECK_EN is defined.
module sys_axi_aw_4kchk
  import sys_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic              cross_o
);

  logic [ADDR_W-1:0] bytes_d;
  logic [ADDR_W-1:0] last_d;

  // Last byte address of the burst, compared page-wise against the start.
  always_comb begin
    bytes_d = (ADDR_W'(len_i) + 1'b1) << size_i;
    last_d  = addr_i + bytes_d - 1'b1;
    cross_o = (burst_i == AXI_BURST_INCR) &&
              (last_d[ADDR_W-1:AXI_4K_SHIFT] != addr_i[ADDR_W-1:AXI_4K_SHIFT]);
  end

endmodule

// File: rtl/sys_axi_aw_fifo.sv
// AXI AW channel FIFO: DEPTH beats, one-cycle latency, no empty bypass.
// Optional sticky 4 KiB crossing flag via SYS_AXI_AW_FIFO_4K_CHECK_EN.
module sys_axi_aw_fifo
  import sys_axi_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = `AXI_ID_WIDTH,
  parameter int unsigned ADDR_W = `AXI_ADDR_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  sys_axi_aw.slave                   s_aw,
  sys_axi_aw.master                  m_aw,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_4k_o,
  output logic [ID_W-1:0]            err_id_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  aw_payload_t       mem_q [DEPTH];
  aw_payload_t       wr_payload;
  aw_payload_t       head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  // Ready depends only on the registered count (held low during reset).
  assign s_aw.awready = rst_ni && (count_q < CW'(DEPTH));
  assign m_aw.awvalid = (count_q != '0);
  assign push         = s_aw.awvalid && s_aw.awready;
  assign pop          = m_aw.awvalid && m_aw.awready;
  assign count_o      = count_q;

  // Pack the incoming channel into the stored word.
  always_comb begin
    wr_payload        = '0;
    wr_payload.id     = s_aw.awid;
    wr_payload.addr   = s_aw.awaddr;
    wr_payload.len    = s_aw.awlen;
    wr_payload.size   = s_aw.awsize;
    wr_payload.burst  = s_aw.awburst;
    wr_payload.lock   = s_aw.awlock;
    wr_payload.cache  = s_aw.awcache;
    wr_payload.prot   = s_aw.awprot;
    wr_payload.qos    = s_aw.awqos;
    wr_payload.region = s_aw.awregion;
  end

  // Head entry drives the downstream channel straight from storage.
  assign head           = mem_q[rd_ptr_q];
  assign m_aw.awid      = head.id;
  assign m_aw.awaddr    = head.addr;
  assign m_aw.awlen     = head.len;
  assign m_aw.awsize    = head.size;
  assign m_aw.awburst   = head.burst;
  assign m_aw.awlock    = head.lock;
  assign m_aw.awcache   = head.cache;
  assign m_aw.awprot    = head.prot;
  assign m_aw.awqos     = head.qos;
  assign m_aw.awregion  = head.region;

  // Next pointers and occupancy; pointers wrap naturally at a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards all buffered entries.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_payload;
  end

`ifdef SYS_AXI_AW_FIFO_4K_CHECK_EN
  logic            cross;
  logic            err_4k_q;
  logic [ID_W-1:0] err_id_q;

  sys_axi_aw_4kchk #(
    .ADDR_W (ADDR_W)
  ) u_4kchk (
    .addr_i  (s_aw.awaddr),
    .len_i   (s_aw.awlen),
    .size_i  (s_aw.awsize),
    .burst_i (s_aw.awburst),
    .cross_o (cross)
  );

  // Sticky error: first crossing burst wins, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_4k_q <= 1'b0;
      err_id_q <= '0;
    end else if (push && cross && !err_4k_q) begin
      err_4k_q <= 1'b1;
      err_id_q <= s_aw.awid;
    end
  end

  assign err_4k_o = err_4k_q;
  assign err_id_o = err_id_q;
`else
  assign err_4k_o = 1'b0;
  assign err_id_o = '0;
`endif

endmodule
